// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a single-cycle datapath for ADD/SUB/logic/
// shift operations and an iterative shift-add multiplier (one multiplier
// bit per clock).
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   a, b          operands, sampled on the accept edge
//   op            opcode, sampled on the accept edge
//   start         request a new operation
//   bus_enable_n  active-low drive enable for bus_out
//   flag_fi_n     active-low flag-register load enable
//   flag_clear_n  active-low synchronous flag clear (wins over load)
//   bus_out       tri-state view of the result register
//   flag_out      flag register {V,N,Z,C}
//   busy          high while a multiply is in progress
//   done          one-cycle pulse after the result register is written
//   dbg_state_o   FSM state (1 = MUL), for observation only
//
// Handshake: an operation is accepted on any rising edge where start=1 and
// busy=0. start while busy=1 is ignored. done is high for the cycle after the
// result register is written, and busy is low in that cycle, so a new start
// may be accepted on the very next edge.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             bus_enable_n,
  input  logic             flag_fi_n,
  input  logic             flag_clear_n,
  output logic [WIDTH-1:0] bus_out,
  output logic [3:0]       flag_out,
  output logic             busy,
  output logic             done,
  output logic             dbg_state_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q;
  logic [3:0]           flags_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 res_we;
  logic [WIDTH-1:0]     res_new;
  logic [3:0]           flags_new;

  // Single-cycle datapath
  logic [WIDTH:0]       add_full;
  logic [WIDTH:0]       sub_full;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;
  logic [2*WIDTH-1:0]   step_sum;

  assign add_full = {1'b0, a} + {1'b0, b};
  // Carry-out of a + ~b + 1: 1 means no borrow.
  assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_c   = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_c   = a[0];
      end
      default: begin
        alu_res = '0;
      end
    endcase
  end

  // Partial-product accumulation for the current multiplier bit.
  assign step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state and write-control logic
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    res_we    = 1'b0;
    res_new   = result_q;
    flags_new = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
          end else begin
            res_we    = 1'b1;
            res_new   = alu_res;
            flags_new = {alu_v, alu_res[WIDTH-1], (alu_res == '0), alu_c};
          end
        end
      end
      S_MUL: begin
        acc_d    = step_sum;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        // Last multiplier bit: step_sum is the complete product.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          res_we    = 1'b1;
          res_new   = step_sum[WIDTH-1:0];
          flags_new = {1'b0, step_sum[WIDTH-1], (step_sum[WIDTH-1:0] == '0),
                       (step_sum[2*WIDTH-1:WIDTH] != '0)};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= 4'b0000;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      done_q   <= res_we;
      if (res_we) begin
        result_q <= res_new;
      end
      if (!flag_clear_n) begin
        flags_q <= 4'b0000;
      end else if (res_we && !flag_fi_n) begin
        flags_q <= flags_new;
      end
    end
  end

  assign bus_out     = bus_enable_n ? {WIDTH{1'bz}} : result_q;
  assign flag_out    = flags_q;
  assign busy        = (state_q == S_MUL);
  assign done        = done_q;
  assign dbg_state_o = (state_q == S_MUL);

endmodule
